systolic_pe_os: RTL and testbench

- Output-stationary systolic MAC processing element for the PE array; the successor to the basic registered-MAC PE.
- Adds four things the basic PE lacks: operand forwarding to east/south neighbours, a job FSM with programmable dot-product length, signed/unsigned mode with saturating accumulation, and a valid/ready result-drain handshake.
- One instance per array cell. The array controller issues i_start/i_len to all cells; the drain logic collects results over the handshake.

---
 rtl/systolic_pe_os.sv | 116 +++++++++++
 tb/tb_systolic_pe_os.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_pe_os.sv
// Output-stationary systolic MAC PE: forwards operands east/south, accumulates a
// programmable-length dot product with saturation, and drains the result over valid/ready.
module systolic_pe_os #(
    parameter int BW     = 8,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 8,
    parameter int SIGNED = 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_valid,
    input  logic [BW-1:0]    i_activation,
    input  logic [BW-1:0]    i_weight,
    output logic [BW-1:0]    o_activation,
    output logic [BW-1:0]    o_weight,
    output logic             o_valid,
    output logic [ACC_W-1:0] o_result,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic             o_busy,
    output logic             o_sat
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    localparam logic             SX      = (SIGNED != 0);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [ACC_W-1:0] ACC_MAX = {SX ? 1'b0 : 1'b1, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t            state, state_nxt;
    logic [BW-1:0]     act_q, wgt_q;
    logic              mac_vld;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt, len;
    logic              start_ok, accept;
    logic [CNT_W-1:0]  cnt_inc;
    logic [ACC_W-1:0]  act_ext, wgt_ext, prod;
    logic [ACC_W:0]    sum;
    logic              ovf;
    logic [ACC_W-1:0]  sum_sat;

    assign start_ok = (state == IDLE) && i_start;
    assign accept   = i_valid && (((state == ACCUM) && (cnt < len)) || (start_ok && (i_len != '0)));
    assign cnt_inc  = cnt + ONE;

    // Extending both operands to ACC_W keeps the low ACC_W product bits exact for either signedness.
    assign act_ext = {{(ACC_W-BW){SX & act_q[BW-1]}}, act_q};
    assign wgt_ext = {{(ACC_W-BW){SX & wgt_q[BW-1]}}, wgt_q};
    assign prod    = act_ext * wgt_ext;
    assign sum     = {SX & acc[ACC_W-1], acc} + {SX & prod[ACC_W-1], prod};
    assign ovf     = SX ? (sum[ACC_W] != sum[ACC_W-1]) : sum[ACC_W];
    assign sum_sat = !ovf ? sum[ACC_W-1:0] : ((SX && sum[ACC_W]) ? ACC_MIN : ACC_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start) begin
                if (i_len == '0)                 state_nxt = HOLD;
                else if (accept && i_len == ONE) state_nxt = DRAIN;
                else                             state_nxt = ACCUM;
            end
            ACCUM:   if (accept && cnt_inc == len) state_nxt = DRAIN;
            DRAIN:   state_nxt = HOLD;
            HOLD:    if (i_result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_activation <= '0;
            o_weight     <= '0;
            o_valid      <= 1'b0;
            act_q        <= '0;
            wgt_q        <= '0;
            mac_vld      <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            len          <= '0;
            o_sat        <= 1'b0;
        end else begin
            o_activation <= i_activation;
            o_weight     <= i_weight;
            o_valid      <= i_valid;
            mac_vld      <= accept;
            if (accept) begin
                act_q <= i_activation;
                wgt_q <= i_weight;
            end
            // mac_vld is always low in IDLE, so clearing acc here never drops a product.
            if (start_ok) begin
                acc   <= '0;
                o_sat <= 1'b0;
                len   <= i_len;
                cnt   <= accept ? ONE : '0;
            end else begin
                if (mac_vld) begin
                    acc <= sum_sat;
                    if (ovf) o_sat <= 1'b1;
                end
                if (state == ACCUM && accept) cnt <= cnt_inc;
            end
        end
    end

    assign o_result_valid = (state == HOLD);
    assign o_result       = (state == HOLD) ? acc : '0;
    assign o_busy         = (state != IDLE);
endmodule

// File: tb/tb_systolic_pe_os.sv
// Bench for systolic_pe_os: three parameterisations share stimulus; job table plus corner sequences.
module tb_systolic_pe_os;
    logic       clk = 1'b0;
    logic       rst;
    logic       start, valid, ready;
    logic [7:0] len, act, wgt;

    logic [7:0]  fa [3];
    logic [7:0]  fw [3];
    logic        fv [3], rv [3], busy [3], sat [3];
    logic [19:0] r20;
    logic [15:0] r16s, r16u;

    always #5 clk = ~clk;

    systolic_pe_os #(.BW(8), .ACC_W(20), .CNT_W(8), .SIGNED(1)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_len(len), .i_valid(valid),
        .i_activation(act), .i_weight(wgt), .o_activation(fa[0]), .o_weight(fw[0]),
        .o_valid(fv[0]), .o_result(r20), .o_result_valid(rv[0]), .i_result_ready(ready),
        .o_busy(busy[0]), .o_sat(sat[0]));

    systolic_pe_os #(.BW(8), .ACC_W(16), .CNT_W(8), .SIGNED(1)) dut16s (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_len(len), .i_valid(valid),
        .i_activation(act), .i_weight(wgt), .o_activation(fa[1]), .o_weight(fw[1]),
        .o_valid(fv[1]), .o_result(r16s), .o_result_valid(rv[1]), .i_result_ready(ready),
        .o_busy(busy[1]), .o_sat(sat[1]));

    systolic_pe_os #(.BW(8), .ACC_W(16), .CNT_W(8), .SIGNED(0)) dut16u (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_len(len), .i_valid(valid),
        .i_activation(act), .i_weight(wgt), .o_activation(fa[2]), .o_weight(fw[2]),
        .o_valid(fv[2]), .o_result(r16u), .o_result_valid(rv[2]), .i_result_ready(ready),
        .o_busy(busy[2]), .o_sat(sat[2]));

    // Expected results per instance: e20 (signed, 20b), e16s (signed, 16b), e16u (unsigned, 16b).
    typedef struct {
        int       len;
        int       a [4];
        int       w [4];
        int       gap;
        int       hold;
        int       e20, e16s, e16u;
        bit [2:0] sat;   // {16u, 16s, 20}
    } job_t;

    job_t jobs [8];
    job_t exp_q [$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input longint actual, input longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_result(input job_t e);
        chk("res20",  r20,  e.e20  & 'hFFFFF);
        chk("res16s", r16s, e.e16s & 'hFFFF);
        chk("res16u", r16u, e.e16u & 'hFFFF);
        chk("sat20",  sat[0], e.sat[0]);
        chk("sat16s", sat[1], e.sat[1]);
        chk("sat16u", sat[2], e.sat[2]);
        chk("busy_hold", busy[0], 1);
    endtask

    task automatic run_job(input job_t j);
        int   waited;
        job_t e;
        exp_q.push_back(j);
        @(negedge clk);
        ready = (j.hold == 0);
        start = 1'b1;
        len   = 8'(j.len);
        valid = (j.len > 0);
        act   = 8'(j.a[0]);
        wgt   = 8'(j.w[0]);
        for (int k = 1; k < j.len; k++) begin
            int g;
            g = (j.gap > 0) ? int'($urandom_range(0, j.gap)) : 0;
            repeat (g) begin
                @(negedge clk);
                start = 1'b0;
                valid = 1'b0;
            end
            @(negedge clk);
            start = 1'b0;
            valid = 1'b1;
            act   = 8'(j.a[k]);
            wgt   = 8'(j.w[k]);
        end
        @(negedge clk);
        start  = 1'b0;
        valid  = 1'b0;
        waited = 0;
        while (!rv[0] && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("latency", waited, (j.len == 0) ? 0 : 1);
        e = exp_q.pop_front();
        check_result(e);
        if (j.hold > 0) begin
            repeat (j.hold) begin
                @(negedge clk);
                chk("hold_valid", rv[0], 1);
                chk("hold_res", r20, e.e20 & 'hFFFFF);
            end
            ready = 1'b1;
        end
        @(negedge clk);
        chk("post_valid", rv[0], 0);
        chk("post_res", r20, 0);
        chk("post_busy", busy[0], 0);
    endtask

    initial begin
        logic [7:0] pa, pw;
        logic       pv;

        jobs[0] = '{4, '{3, -4, 7, 10}, '{2, 5, -1, 10}, 0, 0, 79, 79, 3151, 3'b000};
        jobs[1] = '{4, '{3, -4, 7, 10}, '{2, 5, -1, 10}, 3, 5, 79, 79, 3151, 3'b000};
        jobs[2] = '{3, '{127, 127, 127, 0}, '{127, 127, 127, 0}, 0, 0, 48387, 32767, 48387, 3'b010};
        jobs[3] = '{1, '{1, 0, 0, 0}, '{1, 0, 0, 0}, 0, 0, 1, 1, 1, 3'b000};
        jobs[4] = '{2, '{255, 255, 0, 0}, '{255, 255, 0, 0}, 0, 0, 2, 2, 65535, 3'b100};
        jobs[5] = '{0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0, 0, 0, 0, 3'b000};
        jobs[6] = '{3, '{-128, -128, -128, 0}, '{127, 127, 127, 0}, 1, 2, -48768, -32768, 48768, 3'b010};
        jobs[7] = '{4, '{127, 127, 127, -1}, '{127, 127, 127, 1}, 2, 0, 48386, 32766, 48642, 3'b010};

        rst = 1'b1; start = 1'b0; valid = 1'b0; ready = 1'b0;
        len = '0; act = '0; wgt = '0;
        #12;
        chk("rst_busy", busy[0], 0);
        chk("rst_rv", rv[0], 0);
        chk("rst_res", r20, 0);
        chk("rst_sat", sat[0], 0);
        chk("rst_fv", fv[0], 0);
        chk("rst_fa", fa[0], 0);
        @(negedge clk);
        rst = 1'b0;

        // Forwarding with random operands; no start so nothing is accumulated.
        pa = '0; pw = '0; pv = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("fwd_act", fa[0], pa);
                chk("fwd_wgt", fw[0], pw);
                chk("fwd_vld", fv[0], pv);
                chk("fwd_act16u", fa[2], pa);
                chk("fwd_idle", busy[0], 0);
            end
            act = 8'($urandom); wgt = 8'($urandom); valid = 1'($urandom);
            pa = act; pw = wgt; pv = valid;
        end
        @(negedge clk);
        valid = 1'b0;

        for (int i = 0; i < 8; i++) run_job(jobs[i]);

        // Starts during ACCUM/HOLD/handshake ignored; surplus beats only forwarded.
        @(negedge clk);
        ready = 1'b0; start = 1'b1; len = 8'd2; valid = 1'b1; act = 8'd2; wgt = 8'd3;
        @(negedge clk);
        start = 1'b1; len = 8'd5; valid = 1'b0;
        @(negedge clk);
        start = 1'b0; valid = 1'b1; act = 8'd4; wgt = 8'd5;
        @(negedge clk);
        chk("seq_fwd4", fa[0], 4);
        act = 8'd9; wgt = 8'd9;
        @(negedge clk);
        chk("seq_fwd9", fa[0], 9);
        chk("seq_fwdv", fv[0], 1);
        chk("seq_hold", rv[0], 1);
        chk("seq_res", r20, 26);
        start = 1'b1; act = 8'd11; wgt = 8'd13;
        @(negedge clk);
        chk("seq_fwd11", fa[0], 11);
        chk("seq_fwd13", fw[0], 13);
        chk("seq_hold2", rv[0], 1);
        chk("seq_res2", r20, 26);
        start = 1'b1; len = 8'd3; valid = 1'b0; ready = 1'b1;
        @(negedge clk);
        chk("seq_drop_rv", rv[0], 0);
        chk("seq_drop_busy", busy[0], 0);
        start = 1'b0;
        @(negedge clk);
        chk("seq_still_idle", busy[0], 0);

        // Reset in the middle of a job.
        start = 1'b1; len = 8'd4; valid = 1'b1; act = 8'd5; wgt = 8'd5; ready = 1'b1;
        @(negedge clk);
        start = 1'b0; act = 8'd6; wgt = 8'd6;
        @(negedge clk);
        valid = 1'b0;
        chk("mid_busy", busy[0], 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_rv", rv[0], 0);
        chk("mid_rst_res", r20, 0);
        chk("mid_rst_fv", fv[0], 0);
        chk("mid_rst_fa", fa[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_no_result", rv[0], 0);
        run_job(jobs[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
